// File: rtl/csa_seq_accum_if.sv
// Operand/result handshake bundle for the carry-save sequential multiplier front end.
// master = operand source / result consumer, slave = the accumulator itself.
interface csa_seq_accum_if #(
    parameter int W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   sum_vec;
    logic [2*W-1:0]   carry_vec;
    logic             busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum_vec, carry_vec, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum_vec, carry_vec, busy
    );
endinterface

// File: rtl/csa_seq_accum.sv
// Shift-add multiplier front end: one partial product per cycle folded into a
// carry-save (sum, carry) pair by a 3:2 row; carry resolution is left to the final adder.
module csa_seq_accum #(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst,
    csa_seq_accum_if.slave    bus
);
    localparam int CW = $clog2(W);
    localparam int DW = 2 * W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [DW-1:0]  a_reg, a_next;
    logic [W-1:0]   b_reg, b_next;
    logic [DW-1:0]  acc_s_reg, acc_s_next;
    logic [DW-1:0]  acc_c_reg, acc_c_next;

    logic [DW-1:0]  pp;
    logic [DW-1:0]  csa_sum;
    logic [DW-2:0]  csa_maj;
    logic           last_bit;

    assign pp       = b_reg[cnt_reg] ? (a_reg << cnt_reg) : '0;
    assign last_bit = (cnt_reg == CW'(W - 1));

    // Bitwise 3:2 compressor; the top majority bit would shift out, so it is never formed.
    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_csa
            assign csa_sum[gi] = acc_s_reg[gi] ^ acc_c_reg[gi] ^ pp[gi];
            if (gi < DW - 1) begin : g_maj
                assign csa_maj[gi] = (acc_s_reg[gi] & acc_c_reg[gi])
                                   | (acc_s_reg[gi] & pp[gi])
                                   | (acc_c_reg[gi] & pp[gi]);
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        acc_s_next = acc_s_reg;
        acc_c_next = acc_c_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_next     = {{W{1'b0}}, bus.a};
                    b_next     = bus.b;
                    acc_s_next = '0;
                    acc_c_next = '0;
                    cnt_next   = '0;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                acc_s_next = csa_sum;
                acc_c_next = {csa_maj, 1'b0};
                cnt_next   = cnt_reg + 1'b1;
                if (last_bit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_s_reg <= '0;
            acc_c_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            acc_s_reg <= acc_s_next;
            acc_c_reg <= acc_c_next;
        end
    end

    // Vectors come straight from the accumulators so they stay frozen while DONE waits.
    assign bus.in_ready  = (state_reg == S_IDLE);
    assign bus.busy      = (state_reg == S_RUN);
    assign bus.out_valid = (state_reg == S_DONE);
    assign bus.sum_vec   = acc_s_reg;
    assign bus.carry_vec = acc_c_reg;
endmodule
